// File: rtl/distinct_ctrl_pkg.sv
// Shared key/response/output beat types for the distinct-aggregation datapath.
// Latency: none (types and constants only).
// Backpressure: none here; carriers use valid/ready on metaIntf.
package aggTypes;

  localparam int AGG_KEY_BITS = 16;

  typedef logic [AGG_KEY_BITS-1:0] agg_key_t;

  // Key stream beat and lookup request
  typedef struct packed {
    agg_key_t key;
    logic     last;
  } key_t;

  // Lookup response from the distinct hash table
  typedef struct packed {
    agg_key_t key;
    logic     hit;
    logic     last;
  } rsp_t;

  // Distinct output beat; vld=0 marks an empty batch terminator
  typedef struct packed {
    agg_key_t key;
    logic     vld;
    logic     last;
  } out_t;

endpackage

// File: rtl/distinct_ctrl_if.sv
// Generic valid/ready metadata channel carrying one packed beat.
// Latency: none (wires only).
// Backpressure: beat transfers when valid and ready are both high.
interface metaIntf #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/distinct_ctrl_key_fifo.sv
// Holds keys of outstanding lookups so responses are judged against the issued key.
// Latency: head visible the cycle after push when empty.
// Backpressure: none; the caller's credit counter guarantees it never overflows.
module distinct_key_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d   = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Pointer registers; depth is a power of two so they wrap naturally
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable
  always_ff @(posedge aclk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/distinct_ctrl.sv
// Filters a key batch down to first occurrences using table lookups plus a recent-miss window.
// Latency: s_key fire to m_out valid = 1 + table latency + 1 cycles when unstalled.
// Backpressure: credit-limited to N_OUT outstanding lookups; m_out stall holds the response.
module distinct_ctrl
  import aggTypes::*;
#(
  parameter int N_OUT    = 4,
  parameter int MISS_WIN = 4
) (
  input  logic aclk,
  input  logic aresetn,
  metaIntf.s   s_key,
  metaIntf.m   m_lup_req,
  metaIntf.s   s_lup_rsp,
  metaIntf.m   m_upd_req,
  metaIntf.m   m_out
);
  localparam int CNT_W = $clog2(N_OUT + 1);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             req_vld_q;
  key_t             req_dat_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  agg_key_t         win_key_q [MISS_WIN];
  logic [MISS_WIN-1:0] win_vld_q;
  logic             out_vld_q;
  out_t             out_dat_q;

  key_t             key_in;
  rsp_t             rsp_in;
  agg_key_t         head_key;
  logic [CNT_W:0]   inflight;
  logic             key_rdy, key_fire, lup_fire, rsp_fire;
  logic             slice_free, credit_ok, win_hit, dup, emit;
  out_t             out_beat;
  logic             unused_ok;

  assign key_in = s_key.data;
  assign rsp_in = s_lup_rsp.data;

  // The response key is informational only: in-order responses make the FIFO head authoritative
  assign unused_ok = ^{rsp_in.key, m_upd_req.ready};

  // Request slice plus credit: the slice occupant already holds a credit
  assign slice_free = ~req_vld_q | m_lup_req.ready;
  assign inflight   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, req_vld_q};
  assign credit_ok  = inflight < (CNT_W+1)'(N_OUT);
  assign key_fire   = s_key.valid & key_rdy;
  assign lup_fire   = req_vld_q & m_lup_req.ready;
  assign rsp_fire   = s_lup_rsp.valid & s_lup_rsp.ready;

  assign s_key.ready     = key_rdy;
  assign m_lup_req.valid = req_vld_q;
  assign m_lup_req.data  = req_dat_q;

  // Response classification; only beats that produce output wait on m_out
  assign dup             = rsp_in.hit | win_hit;
  assign emit            = ~dup | rsp_in.last;
  assign s_lup_rsp.ready = emit ? m_out.ready : 1'b1;
  assign m_upd_req.valid = rsp_fire & ~dup;
  assign m_upd_req.data  = head_key;
  assign m_out.valid     = out_vld_q;
  assign m_out.data      = out_dat_q;

  distinct_key_fifo #(
    .W     (AGG_KEY_BITS),
    .DEPTH (N_OUT)
  ) u_key_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push_i     (lup_fire),
    .push_dat_i (req_dat_q.key),
    .pop_i      (rsp_fire),
    .head_dat_o (head_key)
  );

  // Parallel compare of the head key against every live window entry
  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < MISS_WIN; i++) begin
      win_hit = win_hit | (win_vld_q[i] & (win_key_q[i] == head_key));
    end
  end

  // Output beat: the head key on a miss, an empty terminator on a final duplicate
  always_comb begin
    out_beat = '0;
    if (dup) begin
      out_beat.last = 1'b1;
    end else begin
      out_beat.key  = head_key;
      out_beat.vld  = 1'b1;
      out_beat.last = rsp_in.last;
    end
  end

  // Outstanding count moves only when exactly one of request/response fires
  always_comb begin
    cnt_d = cnt_q;
    if (lup_fire && !rsp_fire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!lup_fire && rsp_fire) cnt_d = cnt_q - CNT_W'(1);
  end

  // Next state and accept enable: a final key in the slice blocks the next batch
  always_comb begin
    state_d = state_q;
    key_rdy = 1'b0;
    case (state_q)
      RUN: begin
        key_rdy = slice_free & credit_ok & ~(req_vld_q & req_dat_q.last);
        if (lup_fire && req_dat_q.last) state_d = DRAIN;
      end
      DRAIN: begin
        if (rsp_fire && rsp_in.last) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, counter and request slice registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      req_vld_q <= 1'b0;
      req_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (key_fire) begin
        req_vld_q <= 1'b1;
        req_dat_q <= key_in;
      end else if (lup_fire) begin
        req_vld_q <= 1'b0;
      end
    end
  end

  // Miss window: shift in each new miss, flush when the batch ends
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      win_vld_q <= '0;
      for (int i = 0; i < MISS_WIN; i++) win_key_q[i] <= '0;
    end else if (rsp_fire && rsp_in.last) begin
      win_vld_q <= '0;
    end else if (rsp_fire && !dup) begin
      for (int i = MISS_WIN-1; i > 0; i--) begin
        win_key_q[i] <= win_key_q[i-1];
        win_vld_q[i] <= win_vld_q[i-1];
      end
      win_key_q[0] <= head_key;
      win_vld_q[0] <= 1'b1;
    end
  end

  // Output register: load on an emitting response, drop valid once consumed
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (rsp_fire && emit) begin
      out_vld_q <= 1'b1;
      out_dat_q <= out_beat;
    end else if (m_out.ready) begin
      out_vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_distinct_ctrl.sv
// Self-checking bench: table model with fixed latency, batch-level first-occurrence reference.
// Latency: n/a.
// Backpressure: randomized on lookup request and distinct output channels.
module tb_distinct_ctrl;
  import aggTypes::*;

  localparam int L  = 3;
  localparam int NO = 4;
  localparam int OW = $bits(out_t);

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  metaIntf #(.W($bits(key_t)))  s_key ();
  metaIntf #(.W($bits(key_t)))  lup ();
  metaIntf #(.W($bits(rsp_t)))  rsp ();
  metaIntf #(.W(AGG_KEY_BITS))  upd ();
  metaIntf #(.W(OW))            mout ();

  distinct_ctrl #(.N_OUT(NO), .MISS_WIN(4)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_key     (s_key),
    .m_lup_req (lup),
    .s_lup_rsp (rsp),
    .m_upd_req (upd),
    .m_out     (mout)
  );

  typedef struct { rsp_t r; int due; } tr_t;

  key_t          key_q [$];
  tr_t           rsp_q [$];
  logic [OW-1:0] exp_out [$];
  logic [OW-1:0] got_out [$];
  bit            tbl  [int];
  bit            seen [int];
  int   cyc, n_chk, n_pass, upd_cnt, exp_upd, outstanding, max_out;
  int   hold_err, drain_err, hit_cnt, first_key, first_out;
  int   p_key, p_lrdy, p_ordy;
  bit   pend_last, prev_stall, busy_s, skey_rdy_s;
  logic [OW-1:0] prev_dat;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: within a batch only first occurrences pass; a duplicate last key yields a terminator
  task automatic add_key(input int key, input bit last);
    key_t k;
    out_t o;
    k.key = AGG_KEY_BITS'(key);
    k.last = last;
    key_q.push_back(k);
    o = '0;
    if (!seen.exists(key)) begin
      seen[key] = 1'b1;
      o.key = k.key; o.vld = 1'b1; o.last = last;
      exp_out.push_back(o);
      exp_upd++;
    end else if (last) begin
      o.last = 1'b1;
      exp_out.push_back(o);
    end
    if (last) seen.delete();
  endtask

  // One clock: drive at negedge, observe handshakes 1 time unit later, then advance
  task automatic step();
    key_t k;
    tr_t  t;
    @(negedge aclk);
    s_key.valid = (key_q.size() > 0) && (int'($urandom_range(99)) < p_key);
    s_key.data  = '0;
    if (key_q.size() > 0) s_key.data = key_q[0];
    lup.ready = int'($urandom_range(99)) < p_lrdy;
    rsp.valid = 1'b0;
    rsp.data  = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rsp.valid = 1'b1;
      rsp.data  = rsp_q[0].r;
    end
    mout.ready = int'($urandom_range(99)) < p_ordy;
    #1;
    if (prev_stall && (!mout.valid || mout.data != prev_dat)) hold_err++;
    prev_stall = mout.valid && !mout.ready;
    prev_dat   = mout.data;
    skey_rdy_s = s_key.ready;
    busy_s = lup.valid || mout.valid || (rsp.valid && rsp.ready) || (s_key.valid && s_key.ready);
    if (mout.valid && first_out < 0) first_out = cyc;
    if (s_key.valid && s_key.ready) begin
      if (pend_last) drain_err++;
      k = key_q.pop_front();
      if (k.last) pend_last = 1'b1;
      if (first_key < 0) first_key = cyc;
    end
    if (upd.valid) begin
      tbl[int'(upd.data)] = 1'b1;
      upd_cnt++;
    end
    if (mout.valid && mout.ready) got_out.push_back(mout.data);
    if (lup.valid && lup.ready) begin
      k = lup.data;
      t.r.key  = k.key;
      t.r.hit  = (tbl.exists(int'(k.key)) != 0);
      t.r.last = k.last;
      t.due    = cyc + L;
      if (t.r.hit) hit_cnt++;
      rsp_q.push_back(t);
      outstanding++;
    end
    if (rsp.valid && rsp.ready) begin
      t = rsp_q.pop_front();
      outstanding--;
      if (t.r.last) begin
        tbl.delete();
        pend_last = 1'b0;
      end
    end
    if (outstanding > max_out) max_out = outstanding;
    @(posedge aclk);
    cyc++;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      step();
      n++;
      idle = (key_q.size() == 0) && (rsp_q.size() == 0) && (outstanding == 0) && !busy_s;
    end
    chk({tag, "_idle"}, idle, 1);
  endtask

  task automatic check_batch(input string tag);
    chk({tag, "_nout"}, got_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      chk({tag, "_beat"}, got_out[i], exp_out[i]);
    chk({tag, "_nupd"}, upd_cnt, exp_upd);
    chk({tag, "_hold"}, hold_err, 0);
    chk({tag, "_drain"}, drain_err, 0);
    chk({tag, "_maxout_ok"}, (max_out <= NO), 1);
    got_out.delete(); exp_out.delete();
    upd_cnt = 0; exp_upd = 0; hold_err = 0; drain_err = 0;
    max_out = 0; hit_cnt = 0; first_key = -1; first_out = -1;
  endtask

  initial begin
    s_key.valid = 1'b0; s_key.data = '0;
    lup.ready = 1'b0; rsp.valid = 1'b0; rsp.data = '0;
    upd.ready = 1'b1; mout.ready = 1'b0;
    cyc = 0; n_chk = 0; n_pass = 0; upd_cnt = 0; exp_upd = 0;
    outstanding = 0; max_out = 0; hold_err = 0; drain_err = 0; hit_cnt = 0;
    first_key = -1; first_out = -1; pend_last = 1'b0; prev_stall = 1'b0;
    p_key = 100; p_lrdy = 100; p_ordy = 100;

    // Reset values
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_out_vld", mout.valid, 0);
    chk("rst_out_dat", mout.data, 0);
    chk("rst_lup_vld", lup.valid, 0);
    chk("rst_upd_vld", upd.valid, 0);
    chk("rst_cnt", dut.cnt_q, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rst_skey_rdy", s_key.ready, 1);

    // 5,7,5,9(last): 5 dropped, three updates, latency 1+L+1
    add_key(5, 0); add_key(7, 0); add_key(5, 0); add_key(9, 1);
    run_idle("t_basic", 200);
    chk("t_basic_latency", first_out - first_key, 2 + L);
    check_batch("t_basic");

    // Back-to-back 3,3: table misses both, window drops the second
    add_key(3, 0); add_key(3, 1);
    run_idle("t_window", 200);
    chk("t_window_hits", hit_cnt, 0);
    check_batch("t_window");

    // Two batches; the second may not start until the first drains
    add_key(1, 0); add_key(2, 1); add_key(2, 0); add_key(1, 1);
    run_idle("t_batches", 300);
    check_batch("t_batches");

    // 4,4(last): key then empty terminator
    add_key(4, 0); add_key(4, 1);
    run_idle("t_term", 200);
    check_batch("t_term");

    // Output stalled for 20 cycles with 10 keys offered
    p_ordy = 0;
    for (int i = 0; i < 10; i++) add_key(20 + i, i == 9);
    repeat (20) step();
    chk("t_stall_maxout", max_out, NO);
    chk("t_stall_skey_rdy", skey_rdy_s, 0);
    chk("t_stall_cnt", dut.cnt_q, NO);
    chk("t_stall_no_out", got_out.size(), 0);
    p_ordy = 100;
    run_idle("t_stall", 500);
    check_batch("t_stall");

    // Reset mid-batch
    for (int i = 0; i < 5; i++) add_key(40 + i, i == 4);
    repeat (6) step();
    @(negedge aclk);
    aresetn = 1'b0;
    s_key.valid = 1'b0;
    rsp.valid = 1'b0;
    #1;
    chk("t_rst_out_vld", mout.valid, 0);
    chk("t_rst_out_dat", mout.data, 0);
    chk("t_rst_lup_vld", lup.valid, 0);
    chk("t_rst_upd_vld", upd.valid, 0);
    chk("t_rst_cnt", dut.cnt_q, 0);
    key_q.delete(); rsp_q.delete(); got_out.delete(); exp_out.delete();
    tbl.delete(); seen.delete();
    outstanding = 0; pend_last = 1'b0; prev_stall = 1'b0;
    upd_cnt = 0; exp_upd = 0; max_out = 0; hit_cnt = 0; hold_err = 0; drain_err = 0;
    first_key = -1; first_out = -1;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("t_rst_skey_rdy", s_key.ready, 1);
    add_key(40, 0); add_key(41, 1);
    run_idle("t_post_rst", 200);
    check_batch("t_post_rst");

    // Randomized batches over a small key space with random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 25; b++) begin
        int len;
        len = int'($urandom_range(6, 1));
        for (int i = 0; i < len; i++) add_key(int'($urandom_range(7)), i == len - 1);
      end
      p_key  = int'($urandom_range(100, 40));
      p_lrdy = int'($urandom_range(100, 50));
      p_ordy = int'($urandom_range(100, 30));
      run_idle("rand", 20000);
      check_batch("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/distinct_ctrl.md
DISTINCT_CTRL -- requirements
Module: distinct_ctrl

Interface
REQ-001 SHALL have parameter N_OUT, default 4, meaning max outstanding lookups (power of two, 2..16).
REQ-002 SHALL have parameter MISS_WIN, default 4, meaning depth of recent-miss key window.
REQ-003 SHALL have port aclk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_key  metaIntf.s  AGG_KEY_BITS+1  input key stream {key, last}.
REQ-006 SHALL have port m_lup_req  metaIntf.m  AGG_KEY_BITS+1  lookup request {key, last} to the distinct hash table.
REQ-007 SHALL have port s_lup_rsp  metaIntf.s  AGG_KEY_BITS+2  lookup response {key, hit, last}, in request order.
REQ-008 SHALL have port m_upd_req  metaIntf.m  AGG_KEY_BITS  insert request {key}; the table holds ready permanently high.
REQ-009 SHALL have port m_out  metaIntf.m  AGG_KEY_BITS+2  distinct output {key, vld, last}; vld=0 marks an empty terminator beat.

Function
REQ-010 SHALL forward s_key to m_lup_req through one register slice; s_key.ready = slice free & credit available & state==RUN.
REQ-011 SHALL keep outstanding counter cnt (0..N_OUT): +1 on lup_req fire, -1 on lup_rsp fire, unchanged when both fire together.
REQ-012 SHALL deassert s_key.ready when cnt==N_OUT, with no request issued in that cycle.
REQ-013 SHALL hold the request key in a FIFO of depth N_OUT, popped on response; the response is processed against the FIFO head key, not rsp.key.
REQ-014 SHALL declare a response duplicate when rsp.hit=1 or the head key matches any valid window entry.
REQ-015 On a non-duplicate, SHALL emit m_out {key, vld=1, last} and one m_upd_req {key} in the same cycle as lup_rsp fires.
REQ-016 On a non-duplicate, SHALL push the key into the miss window (FIFO replacement, oldest evicted).
REQ-017 On a duplicate without last, SHALL drop the response: no m_out, no update; s_lup_rsp.ready=1.
REQ-018 On a duplicate with last=1, SHALL emit m_out {key=0, vld=0, last=1}.
REQ-019 SHALL set s_lup_rsp.ready = m_out.ready whenever the response produces an m_out beat, otherwise 1.
REQ-020 m_out SHALL be registered; data SHALL hold stable while valid & ~ready.
REQ-021 FSM states SHALL be RUN and DRAIN; RUN->DRAIN when a request with last=1 fires.
REQ-022 DRAIN->RUN when the last=1 response fires; no s_key accepted in DRAIN.
REQ-023 The last=1 response SHALL clear all window entries in the same cycle (table clears its valid bits on last).
REQ-024 Latency s_key fire -> m_out valid SHALL be 1 + table latency + 1 cycles when unstalled.
REQ-025 Throughput SHALL be one key per cycle while cnt<N_OUT and m_out.ready=1.
REQ-026 Hash-collision misses SHALL pass as distinct; no further filtering.

Reset
REQ-027 On aresetn=0, asynchronously: all valid outputs 0, cnt=0, FIFO and window empty, state=RUN, m_out.data=0.
REQ-028 Reset mid-batch SHALL discard in-flight requests; responses arriving after release are the environment's responsibility.

Structure
REQ-029 AGG_KEY_BITS and the key/rsp/out struct typedefs SHALL live in aggTypes; FSM enum local.
REQ-030 Request key FIFO SHALL be a sub-module distinct_key_fifo (depth N_OUT, pop on response).
REQ-031 Window compare SHALL be a parallel MISS_WIN-way equality, combinational into the response path.

Verification
REQ-032 Keys 5,7,5,9(last), table model latency 3 -> m_out 5,7,9(last); 3 updates; key 5 dropped.
REQ-033 Back-to-back 3,3 with table hit=0 for both -> second 3 dropped via window; one update only.
REQ-034 Batch 1,2(last) then batch 2,1(last) -> outputs 1,2(last),2,1(last); second batch waits until DRAIN exits.
REQ-035 Keys 4,4(last) -> m_out 4, then {0,vld=0,last=1}.
REQ-036 m_out.ready=0 for 20 cycles with 10 keys offered -> cnt saturates at 4, s_key.ready=0, no data lost or reordered.
REQ-037 aresetn low mid-batch -> all outputs 0 immediately, cnt=0, state=RUN after release.
